conjugation_seq_ctrl: RTL

- Sequencer for the conjugation register array: the N x N tableau of 2-bit Pauli literals plus one phase bit per row.
- Accepts one command at a time over a valid/ready interface:
  - streamed row load;
  - streamed row readout;
  - single-qubit Clifford/Pauli conjugation on a chosen qubit column.
- Conjugation is done by one full left rotation, with the update injected at the target column.
- Drives every array control/data input and observes the array's left_out, literals_out and phase_out.

---
 rtl/conjugation_seq_ctrl_pkg.sv | 20 ++
 rtl/conjugation_seq_ctrl_gate_lut.sv | 24 ++
 rtl/conjugation_seq_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/conjugation_seq_ctrl_pkg.sv
// conj_pkg: opcodes, Pauli literal encodings and sequencer state type
// shared by the conjugation sequencer and its per-row gate lookup.
// Literal encoding: bit1 = x, bit0 = z.
package conj_pkg;
    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_READ = 3'b001;
    localparam logic [2:0] OP_H    = 3'b010;
    localparam logic [2:0] OP_S    = 3'b011;
    localparam logic [2:0] OP_PX   = 3'b100;
    localparam logic [2:0] OP_PY   = 3'b101;
    localparam logic [2:0] OP_PZ   = 3'b110;
    localparam logic [2:0] OP_ILL  = 3'b111;

    localparam logic [1:0] LIT_I = 2'b00;
    localparam logic [1:0] LIT_X = 2'b10;
    localparam logic [1:0] LIT_Z = 2'b01;
    localparam logic [1:0] LIT_Y = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_READ, S_GATE, S_FIN} state_t;
endpackage

// File: rtl/conjugation_seq_ctrl_gate_lut.sv
// conj_gate_lut: single-qubit Clifford/Pauli conjugation of one literal.
// Ports: op   - gate opcode (H, S, PX, PY, PZ; anything else passes through)
//        lit  - literal being conjugated
//        upd  - conjugated literal
//        flip - 1 when the row phase must toggle
module conj_gate_lut
    import conj_pkg::*;
(
    input  logic [2:0] op,
    input  logic [1:0] lit,
    output logic [1:0] upd,
    output logic       flip
);
    // H swaps x/z and negates Y; S maps X->Y, Y->-X; Paulis only touch the sign
    // of literals that anticommute with them.
    always_comb begin
        upd  = (op == OP_H) ? {lit[0], lit[1]} :
               (op == OP_S) ? {lit[1], lit[0] ^ lit[1]} : lit;
        flip = (op == OP_H || op == OP_S) ? (lit[1] & lit[0]) :
               (op == OP_PX) ? lit[0] :
               (op == OP_PZ) ? lit[1] :
               (op == OP_PY) ? (lit[1] ^ lit[0]) : 1'b0;
    end
endmodule

// File: rtl/conjugation_seq_ctrl.sv
// conjugation_seq_ctrl: command sequencer for the N x N conjugation register
// array (2-bit Pauli literals plus one phase bit per row).
// Ports:
//   cmd_valid/cmd_ready/cmd_op/cmd_qubit  - one command at a time
//   in_valid/in_ready/in_literals/in_phase     - streamed row load
//   out_valid/out_ready/out_literals/out_phase - streamed row readout
//   busy, done (pulse), err (pulse on illegal command)
//   ld_literal, ld_phase, shift_rotate_literal, shift_toggle_phase,
//   rotate_update_literal, literals_in, phase_in, update_literal - array controls
//   left_out, literals_out, phase_out - array observations
module conjugation_seq_ctrl
    import conj_pkg::*;
#(
    parameter int num_qubit = 4,
    parameter int QW        = $clog2(num_qubit)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [2:0]             cmd_op,
    input  logic [QW-1:0]          cmd_qubit,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2*num_qubit-1:0] in_literals,
    input  logic                   in_phase,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*num_qubit-1:0] out_literals,
    output logic                   out_phase,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic                   ld_literal,
    output logic [num_qubit-1:0]   ld_phase,
    output logic                   shift_rotate_literal,
    output logic                   shift_toggle_phase,
    output logic                   rotate_update_literal,
    output logic [2*num_qubit-1:0] literals_in,
    output logic                   phase_in,
    output logic [2*num_qubit-1:0] update_literal,
    input  logic [2*num_qubit-1:0] left_out,
    input  logic [2*num_qubit-1:0] literals_out,
    input  logic                   phase_out
);
    localparam int N = num_qubit;

    state_t         state, state_n;
    logic [QW-1:0]  cnt, cnt_n, qubit_r;
    logic [2:0]     op_r;
    logic           err_n;
    logic           hit, last, legal;
    logic [2*N-1:0] upd_all;
    logic [N-1:0]   flip_all;

    // During GATE the array's left column holds original column cnt, so the
    // update is injected exactly when that column is the target qubit.
    assign hit   = (state == S_GATE) && (cnt == qubit_r);
    assign last  = cnt == QW'(N - 1);
    assign legal = cmd_op == OP_LOAD || cmd_op == OP_READ ||
                   (cmd_op != OP_ILL && int'(cmd_qubit) < N);

    for (genvar i = 0; i < N; i++) begin : g_lut
        conj_gate_lut u_lut (
            .op  (op_r),
            .lit (left_out[2*i +: 2]),
            .upd (upd_all[2*i +: 2]),
            .flip(flip_all[i])
        );
    end

    assign update_literal = hit ? upd_all : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            op_r    <= OP_LOAD;
            qubit_r <= '0;
            err     <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            err   <= err_n;
            if (cmd_valid && cmd_ready) begin
                op_r    <= cmd_op;
                qubit_r <= cmd_qubit;
            end
        end
    end

    always_comb begin
        state_n               = state;
        cnt_n                 = cnt;
        err_n                 = 1'b0;
        cmd_ready             = 1'b0;
        busy                  = state != S_IDLE;
        done                  = 1'b0;
        in_ready              = 1'b0;
        out_valid             = 1'b0;
        out_literals          = '0;
        out_phase             = 1'b0;
        ld_literal            = 1'b0;
        ld_phase              = '0;
        shift_rotate_literal  = 1'b0;
        shift_toggle_phase    = 1'b0;
        rotate_update_literal = 1'b0;
        literals_in           = '0;
        phase_in              = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    cnt_n   = '0;
                    err_n   = !legal;
                    state_n = !legal ? S_IDLE :
                              (cmd_op == OP_LOAD) ? S_LOAD :
                              (cmd_op == OP_READ) ? S_READ : S_GATE;
                end
            end
            S_LOAD: begin
                in_ready    = 1'b1;
                literals_in = in_literals;
                phase_in    = in_phase;
                ld_literal  = in_valid;
                ld_phase    = {N{in_valid}};
                if (in_valid) begin
                    cnt_n   = cnt + 1'b1;
                    state_n = last ? S_FIN : S_LOAD;
                end
            end
            S_READ: begin
                // Shift down while feeding all-I rows: the bottom row is output
                // and the tableau is cleared as it drains.
                out_valid    = 1'b1;
                out_literals = literals_out;
                out_phase    = phase_out;
                ld_literal   = out_ready;
                ld_phase     = {N{out_ready}};
                if (out_ready) begin
                    cnt_n   = cnt + 1'b1;
                    state_n = last ? S_FIN : S_READ;
                end
            end
            S_GATE: begin
                ld_literal            = 1'b1;
                shift_rotate_literal  = 1'b1;
                rotate_update_literal = hit;
                shift_toggle_phase    = hit;
                ld_phase              = hit ? flip_all : '0;
                cnt_n                 = cnt + 1'b1;
                state_n               = last ? S_FIN : S_GATE;
            end
            S_FIN: begin
                done    = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end
endmodule
